// File: rtl/acs_node.sv
// Add-compare-select node for one state of a rate-1/2 hard-decision Viterbi trellis; optional clamp via ACS_SAT_EN.
// Latency: 1 cycle from in_valid to out_valid, with back-to-back steps every cycle.
// Backpressure: none. Inputs are accepted only in RUN, and frame_start overrides a coincident in_valid.
module acs_node #(
    parameter int PM_W      = 6,
    parameter int STATE_IDX = 0,
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_start,
    input  logic            in_valid,
    input  logic [PM_W-1:0] pm_a_in,
    input  logic [PM_W-1:0] pm_b_in,
    input  logic [1:0]      bm_a_in,
    input  logic [1:0]      bm_b_in,
    input  logic            norm_in,
    output logic [PM_W-1:0] pm_out,
    output logic            dec_out,
    output logic            out_valid,
    output logic            norm_req,
    output logic            frame_done,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [PM_W-1:0]  PM_INIT  = (STATE_IDX == 0) ? '0 : '1;
    localparam logic [PM_W-1:0]  NORM_Q   = PM_W'(1) << (PM_W - 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    state_t           state;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_cnt_inc;
    logic [PM_W:0]    sum_a;
    logic [PM_W:0]    sum_b;
    logic             sel_b;
    logic [PM_W-1:0]  pm_sel;
    logic [PM_W-1:0]  pm_next;

    // Sums carry one extra bit so the compare is exact even when a metric overflows.
    always_comb begin
        sum_a = {1'b0, pm_a_in} + {{(PM_W-1){1'b0}}, bm_a_in};
        sum_b = {1'b0, pm_b_in} + {{(PM_W-1){1'b0}}, bm_b_in};
        sel_b = (sum_b < sum_a);
    end

`ifdef ACS_SAT_EN
    logic [PM_W:0] sel_sum;

    always_comb begin
        sel_sum = sel_b ? sum_b : sum_a;
        pm_sel  = sel_sum[PM_W] ? '1 : sel_sum[PM_W-1:0];
    end
`else
    // Without the clamp the metric wraps, and overflow is avoided by normalization alone.
    always_comb begin
        pm_sel = sel_b ? sum_b[PM_W-1:0] : sum_a[PM_W-1:0];
    end
`endif

    always_comb begin
        pm_next = pm_sel;
        if (norm_in) begin
            pm_next = (pm_sel >= NORM_Q) ? (pm_sel - NORM_Q) : '0;
        end
        step_cnt_inc = step_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pm_out     <= '0;
            dec_out    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            step_cnt   <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                pm_out   <= PM_INIT;
                step_cnt <= '0;
                state    <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (in_valid) begin
                            pm_out    <= pm_next;
                            dec_out   <= sel_b;
                            out_valid <= 1'b1;
                            step_cnt  <= step_cnt_inc;
                            if (step_cnt_inc == LAST_CNT) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy     = (state == RUN);
    assign norm_req = pm_out[PM_W-1];

endmodule

// File: doc/acs_node.md
Name: acs_node

Overview:
- Add-compare-select node for the rate-1/2 hard-decision Viterbi trellis. Sits directly downstream of the per-state branch metric units.
- Each node receives the two 2-bit branch metrics for its incoming transitions and the path metrics of its two predecessor states.
- Each step it produces a registered survivor path metric plus a 1-bit decision for the traceback memory.
- Frame-level step counting and normalization handshake are included.

Parameters:
- PM_W, 6, path metric width in bits (>=4).
- STATE_IDX, 0, trellis state index of this node; index 0 initialises to metric 0, all others to all-ones.
- FRAME_LEN, 64, trellis steps per frame.
- CNT_W, 7, step counter width; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse; reinitialises the metric and starts a frame.
- in_valid  in  1  one trellis step of inputs valid this cycle.
- pm_a_in  in  PM_W  path metric of predecessor A (upper branch).
- pm_b_in  in  PM_W  path metric of predecessor B (lower branch).
- bm_a_in  in  2  branch metric of A->this transition (0..2).
- bm_b_in  in  2  branch metric of B->this transition (0..2).
- norm_in  in  1  global normalize command, sampled with in_valid.
- pm_out  out  PM_W  registered survivor path metric.
- dec_out  out  1  registered decision: 0 = A chosen, 1 = B chosen.
- out_valid  out  1  one-cycle pulse; pm_out/dec_out updated.
- norm_req  out  1  pm_out >= 2^(PM_W-1); ORed globally by the top level.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.
- busy  out  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; pm_out = 0; dec_out = 0; out_valid = 0; frame_done = 0; counter = 0.
- FSM states:
  - IDLE: in_valid ignored. frame_start -> RUN.
  - RUN: each in_valid cycle is one step. Counter increments; at count == FRAME_LEN -> DONE.
  - DONE: in_valid ignored. frame_start -> RUN.
- frame_start in any state:
  - pm_out <= 0 if STATE_IDX == 0, else all-ones.
  - Counter <= 0; state <= RUN; no out_valid.
  - If in_valid is asserted in the same cycle it is dropped.
- Step arithmetic, computed in PM_W+1 bits:
  - sum_a = pm_a_in + bm_a_in; sum_b = pm_b_in + bm_b_in.
  - Select the smaller sum; on a tie select A, dec = 0.
  - Selected sum > 2^PM_W - 1: clamp to all-ones (see optional feature).
  - norm_in high with in_valid: subtract 2^(PM_W-2) from the clamped value, floor at 0.
- Latency: 1 cycle. Result and dec_out are registered at the edge sampling in_valid; out_valid is high the following cycle for exactly one cycle.
- pm_out and dec_out hold their values between steps.
- norm_req is decoded from the registered pm_out. It is not sticky.
- frame_done asserts together with the out_valid of step FRAME_LEN. The next in_valid in DONE produces no out_valid.
- Back-to-back in_valid every cycle is supported with no bubbles.
- Reset mid-frame returns to IDLE immediately and discards the step in flight.

Optional Feature:
- Macro ACS_SAT_EN.
- Defined: selected sums exceeding all-ones clamp to all-ones, as specified above.
- Undefined: the selected sum is truncated to PM_W bits (wrap-around). The system then relies solely on the norm_req/norm_in handshake to prevent overflow; clamp logic is removed.

Test Plan (PM_W=6, FRAME_LEN=64; all other nodes idle):
- Reset then frame_start, STATE_IDX=0 -> pm_out=0, busy=1, out_valid=0. With STATE_IDX=1 -> pm_out=63.
- pm_a=10, bm_a=2, pm_b=9, bm_b=1 -> next cycle pm_out=10, dec_out=1, out_valid=1 for one cycle. Then swap to pm_b=11 -> pm_out=12, dec_out=0; tie 12/12 -> dec_out=0.
- pm_a=40, bm_a=0, pm_b=45, bm_b=2, norm_in=1 -> pm_out=24, norm_req=0. With norm_in=0 -> pm_out=40, norm_req=1.
- pm_a=62, bm_a=2, pm_b=63, bm_b=2:
  - ACS_SAT_EN defined -> pm_out=63.
  - ACS_SAT_EN undefined -> pm_out=0.
- 64 consecutive in_valid cycles -> 64 out_valid pulses; frame_done is high only with the 64th; busy drops. A 65th in_valid gives no out_valid. frame_start together with in_valid in DONE -> re-init and no out_valid.
- rst_n pulsed low mid-frame (step 30) with in_valid high -> outputs zero within the same cycle and no out_valid follows. After release, IDLE ignores in_valid until frame_start.
